// File: rtl/hdc_sram_responder_pkg.sv
// Shared constants and types for the item-memory / projection-matrix responder.
package hdc_sram_responder_pkg;

    // Hypervector width used when the instantiating level does not override HV_DIM.
    localparam int HV_DIMENSION      = 64;

    localparam int SRAM_ADDR_WIDTH   = 8;
    localparam int SRAM_READ_LATENCY = 2;

    // Wide enough for READ_LATENCY-1 over the legal latency range 1..4.
    localparam int LAT_CNT_W         = 2;

    localparam logic [1:0] LOAD_SEL_IM   = 2'd0;
    localparam logic [1:0] LOAD_SEL_PNEG = 2'd1;
    localparam logic [1:0] LOAD_SEL_PPOS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } rsp_state_t;

    // Counter preload for an accepted request: the read happens when it reaches zero.
    function automatic logic [LAT_CNT_W-1:0] lat_preload(input int read_latency);
        return LAT_CNT_W'(read_latency - 1);
    endfunction

endpackage

// File: rtl/hdc_hv_sram.sv
// Single-port hypervector array with one shared address, a write port and a
// registered, enable-gated read. The read register doubles as the response
// output register, so it is the only part that is reset.
module hdc_hv_sram
    import hdc_sram_responder_pkg::*;
#(
    parameter int HV_DIM = HV_DIMENSION,
    parameter int ADDR_W = SRAM_ADDR_WIDTH
) (
    input  logic              Clk_CI,
    input  logic              Reset_RI,
    input  logic              WrEn_SI,
    input  logic              RdEn_SI,
    input  logic [ADDR_W-1:0] Addr_DI,
    input  logic [HV_DIM-1:0] WrData_DI,
    output logic [HV_DIM-1:0] RdData_DO
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [HV_DIM-1:0] r_mem [DEPTH];
    logic [HV_DIM-1:0] r_rd_data;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge Clk_CI) begin
        if (WrEn_SI) begin
            r_mem[Addr_DI] <= WrData_DI;
        end
    end

    // Registered read; holds the last word until the next enabled read.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RI) begin
            r_rd_data <= '0;
        end else if (RdEn_SI) begin
            r_rd_data <= r_mem[Addr_DI];
        end
    end

    assign RdData_DO = r_rd_data;

endmodule

// File: rtl/hdc_sram_responder.sv
// Memory-side responder for one modality of the spatial encoder. Accepts an
// address, waits READ_LATENCY cycles, then presents the IM word and the two
// projection masks under a valid/ready handshake. Loads are only honoured
// while idle; loads arriving mid-transaction are dropped and flagged.
//
//   state | meaning
//   IDLE  | waiting; loads are written here and take priority over requests
//   READ  | latency counter running; memories read when it reaches zero
//   HOLD  | response words valid, waiting for the encoder to take them
module hdc_sram_responder
    import hdc_sram_responder_pkg::*;
#(
    parameter int HV_DIM       = HV_DIMENSION,
    parameter int ADDR_W       = SRAM_ADDR_WIDTH,
    // Legal range 1..4; the latency counter is sized for that range.
    parameter int READ_LATENCY = SRAM_READ_LATENCY
) (
    input  logic              Clk_CI,
    input  logic              Reset_RI,
    input  logic              ReqValid_SI,
    output logic              ReqReady_SO,
    input  logic [ADDR_W-1:0] Addr_DI,
    output logic              RspValid_SO,
    input  logic              RspReady_SI,
    output logic [HV_DIM-1:0] IMOut_DO,
    output logic [HV_DIM-1:0] ProjNegOut_DO,
    output logic [HV_DIM-1:0] ProjPosOut_DO,
    input  logic              LoadEn_SI,
    input  logic [1:0]        LoadSel_DI,
    input  logic [ADDR_W-1:0] LoadAddr_DI,
    input  logic [HV_DIM-1:0] LoadData_DI,
    output logic              LoadDropped_SO
);

    localparam logic [LAT_CNT_W-1:0] CNT_PRELOAD = lat_preload(READ_LATENCY);

    rsp_state_t             r_state;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_rsp_valid;
    logic                   r_load_dropped;

    logic                   w_idle;
    logic                   w_hold;
    logic                   w_accept;
    logic                   w_rd_en;
    logic                   w_load_ok;
    logic                   w_we_im;
    logic                   w_we_pneg;
    logic                   w_we_ppos;
    logic [ADDR_W-1:0]      w_mem_addr;

    assign w_idle = (r_state == ST_IDLE);
    assign w_hold = (r_state == ST_HOLD);

    // A pending load blocks requests in IDLE; in HOLD a new request may ride on
    // the response handshake for back-to-back operation.
    assign ReqReady_SO = (w_idle & ~LoadEn_SI) | (w_hold & RspReady_SI);
    assign w_accept    = ReqValid_SI & ReqReady_SO;

    assign w_rd_en   = (r_state == ST_READ) && (r_cnt == '0);
    assign w_load_ok = w_idle & LoadEn_SI;
    assign w_we_im   = w_load_ok && (LoadSel_DI == LOAD_SEL_IM);
    assign w_we_pneg = w_load_ok && (LoadSel_DI == LOAD_SEL_PNEG);
    assign w_we_ppos = w_load_ok && (LoadSel_DI == LOAD_SEL_PPOS);

    // Writes only happen in IDLE and reads only in READ, so one address bus
    // per array is enough.
    assign w_mem_addr = w_load_ok ? LoadAddr_DI : r_addr;

    // Request/response FSM with latency counter, address latch and drop flag.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RI) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_rsp_valid    <= 1'b0;
            r_load_dropped <= 1'b0;
        end else begin
            if (LoadEn_SI && !w_idle) begin
                r_load_dropped <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= Addr_DI;
                        r_cnt   <= CNT_PRELOAD;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (RspReady_SI) begin
                        r_rsp_valid <= 1'b0;
                        if (w_accept) begin
                            r_addr  <= Addr_DI;
                            r_cnt   <= CNT_PRELOAD;
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign RspValid_SO    = r_rsp_valid;
    assign LoadDropped_SO = r_load_dropped;

    hdc_hv_sram #(
        .HV_DIM (HV_DIM),
        .ADDR_W (ADDR_W)
    ) u_sram_im (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .WrEn_SI   (w_we_im),
        .RdEn_SI   (w_rd_en),
        .Addr_DI   (w_mem_addr),
        .WrData_DI (LoadData_DI),
        .RdData_DO (IMOut_DO)
    );

    hdc_hv_sram #(
        .HV_DIM (HV_DIM),
        .ADDR_W (ADDR_W)
    ) u_sram_pneg (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .WrEn_SI   (w_we_pneg),
        .RdEn_SI   (w_rd_en),
        .Addr_DI   (w_mem_addr),
        .WrData_DI (LoadData_DI),
        .RdData_DO (ProjNegOut_DO)
    );

    hdc_hv_sram #(
        .HV_DIM (HV_DIM),
        .ADDR_W (ADDR_W)
    ) u_sram_ppos (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .WrEn_SI   (w_we_ppos),
        .RdEn_SI   (w_rd_en),
        .Addr_DI   (w_mem_addr),
        .WrData_DI (LoadData_DI),
        .RdData_DO (ProjPosOut_DO)
    );

endmodule

// File: tb/tb_hdc_sram_responder.sv
// Scoreboard bench for hdc_sram_responder: accepted requests push the expected
// words into a queue; a negedge monitor pops and compares on every handshake.
module tb_hdc_sram_responder;

    localparam int W  = 64;
    localparam int AW = 8;
    localparam int L  = 2;

    localparam logic [W-1:0] P_ALT  = {32{2'b10}};
    localparam logic [W-1:0] P_ONES = {W{1'b1}};
    localparam logic [W-1:0] P_ZERO = {W{1'b0}};

    logic          Clk_CI = 1'b0;
    logic          Reset_RI;
    logic          ReqValid_SI;
    logic          ReqReady_SO;
    logic [AW-1:0] Addr_DI;
    logic          RspValid_SO;
    logic          RspReady_SI;
    logic [W-1:0]  IMOut_DO;
    logic [W-1:0]  ProjNegOut_DO;
    logic [W-1:0]  ProjPosOut_DO;
    logic          LoadEn_SI;
    logic [1:0]    LoadSel_DI;
    logic [AW-1:0] LoadAddr_DI;
    logic [W-1:0]  LoadData_DI;
    logic          LoadDropped_SO;

    hdc_sram_responder #(
        .HV_DIM       (W),
        .ADDR_W       (AW),
        .READ_LATENCY (L)
    ) dut (
        .Clk_CI         (Clk_CI),
        .Reset_RI       (Reset_RI),
        .ReqValid_SI    (ReqValid_SI),
        .ReqReady_SO    (ReqReady_SO),
        .Addr_DI        (Addr_DI),
        .RspValid_SO    (RspValid_SO),
        .RspReady_SI    (RspReady_SI),
        .IMOut_DO       (IMOut_DO),
        .ProjNegOut_DO  (ProjNegOut_DO),
        .ProjPosOut_DO  (ProjPosOut_DO),
        .LoadEn_SI      (LoadEn_SI),
        .LoadSel_DI     (LoadSel_DI),
        .LoadAddr_DI    (LoadAddr_DI),
        .LoadData_DI    (LoadData_DI),
        .LoadDropped_SO (LoadDropped_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int cyc = 0;
    always @(posedge Clk_CI) cyc <= cyc + 1;

    typedef struct {
        int           acc;
        logic [W-1:0] im;
        logic [W-1:0] neg;
        logic [W-1:0] pos;
    } exp_t;

    exp_t         exp_q[$];
    int           hs_cyc[$];
    int           hs_count = 0;
    int           errors   = 0;
    int           checks   = 0;
    logic [W-1:0] m_im  [256];
    logic [W-1:0] m_neg [256];
    logic [W-1:0] m_pos [256];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency, stability under backpressure, and data at each handshake.
    logic         stall = 1'b0;
    logic [W-1:0] h_im, h_neg, h_pos;
    always @(negedge Clk_CI) begin
        if (!Reset_RI) begin
            stall = 1'b0;
        end else begin
            if (RspValid_SO) begin
                chk("req_ready_in_hold", W'(ReqReady_SO), W'(RspReady_SI));
                if (stall) begin
                    chk("hold_im_stable", IMOut_DO, h_im);
                    chk("hold_neg_stable", ProjNegOut_DO, h_neg);
                    chk("hold_pos_stable", ProjPosOut_DO, h_pos);
                end else if (exp_q.size() > 0) begin
                    chk("latency", W'(cyc - exp_q[0].acc), W'(L));
                end
                if (RspReady_SI) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got valid at cycle %0d expected none", cyc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_im", IMOut_DO, e.im);
                        chk("rsp_neg", ProjNegOut_DO, e.neg);
                        chk("rsp_pos", ProjPosOut_DO, e.pos);
                    end
                    hs_count++;
                    hs_cyc.push_back(cyc);
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    h_im  = IMOut_DO;
                    h_neg = ProjNegOut_DO;
                    h_pos = ProjPosOut_DO;
                end
            end
            if (ReqValid_SI && ReqReady_SO) begin
                exp_q.push_back('{cyc + 1, m_im[Addr_DI], m_neg[Addr_DI], m_pos[Addr_DI]});
            end
        end
    end

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [AW-1:0] a, input logic [W-1:0] d);
        LoadEn_SI   = 1'b1;
        LoadSel_DI  = sel;
        LoadAddr_DI = a;
        LoadData_DI = d;
        case (sel)
            2'd0:    m_im[a]  = d;
            2'd1:    m_neg[a] = d;
            2'd2:    m_pos[a] = d;
            default: ;
        endcase
        tick();
        LoadEn_SI = 1'b0;
    endtask

    // Presents a request until accepted; returns the number of edges it took.
    task automatic req(input logic [AW-1:0] a, input bit keep, output int tries);
        logic acc;
        ReqValid_SI = 1'b1;
        Addr_DI     = a;
        acc         = 1'b0;
        tries       = 0;
        while (!acc && tries < 30) begin
            @(negedge Clk_CI);
            acc = ReqReady_SO;
            tick();
            tries++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL req_timeout: got no accept for addr %h expected accept", a);
        end
        if (!keep) ReqValid_SI = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 40) begin
            tick();
            n++;
        end
        chk("handshake_count", W'(hs_count), W'(target));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!RspValid_SO && n < 20) begin
            tick();
            n++;
        end
        chk("valid_seen", W'(RspValid_SO), W'(1));
    endtask

    int nhs = 0;
    int t;

    initial begin
        Reset_RI    = 1'b0;
        ReqValid_SI = 1'b0;
        Addr_DI     = '0;
        RspReady_SI = 1'b0;
        LoadEn_SI   = 1'b0;
        LoadSel_DI  = 2'd3;
        LoadAddr_DI = '0;
        LoadData_DI = '0;
        for (int i = 0; i < 256; i++) begin
            m_im[i]  = '0;
            m_neg[i] = '0;
            m_pos[i] = '0;
        end
        repeat (3) tick();
        Reset_RI = 1'b1;
        tick();

        // Reset / idle
        chk("rst_req_ready", W'(ReqReady_SO), W'(1));
        chk("rst_rsp_valid", W'(RspValid_SO), W'(0));
        chk("rst_im", IMOut_DO, P_ZERO);
        chk("rst_neg", ProjNegOut_DO, P_ZERO);
        chk("rst_pos", ProjPosOut_DO, P_ZERO);
        chk("rst_dropped", W'(LoadDropped_SO), W'(0));

        // Contents; the sel=3 load at 0x05 must write nothing
        load(2'd0, 8'h05, P_ALT);
        load(2'd1, 8'h05, P_ONES);
        load(2'd2, 8'h05, P_ZERO);
        load(2'd3, 8'h05, 64'h0000_0000_0000_DEAD);
        load(2'd0, 8'h00, 64'h0123_4567_89AB_CDEF);
        load(2'd1, 8'h00, 64'h00FF_00FF_00FF_00FF);
        load(2'd2, 8'h00, 64'hFF00_FF00_FF00_FF00);
        load(2'd0, 8'h01, 64'h1111_2222_3333_4444);
        load(2'd1, 8'h01, 64'h5555_6666_7777_8888);
        load(2'd2, 8'h01, 64'h9999_AAAA_BBBB_CCCC);
        load(2'd0, 8'h02, 64'hDEAD_BEEF_0000_0002);
        load(2'd1, 8'h02, 64'h0F0F_0F0F_0F0F_0F0F);
        load(2'd2, 8'h02, 64'hF0F0_F0F0_F0F0_F0F0);
        load(2'd0, 8'hFF, 64'hFFFF_0000_FFFF_0000);
        load(2'd1, 8'hFF, 64'h8000_0000_0000_0001);
        load(2'd2, 8'hFF, 64'h7FFF_FFFF_FFFF_FFFE);

        // Single read, ready held high: one-cycle valid pulse
        RspReady_SI = 1'b1;
        req(8'h05, 1'b0, t);
        nhs++;
        wait_hs(nhs);
        chk("single_pulse_done", W'(RspValid_SO), W'(0));
        chk("single_im_kept", IMOut_DO, P_ALT);

        // Back-to-back
        hs_cyc.delete();
        req(8'h00, 1'b1, t);
        req(8'h01, 1'b1, t);
        req(8'h02, 1'b0, t);
        nhs += 3;
        wait_hs(nhs);
        chk("b2b_count", W'(hs_cyc.size()), W'(3));
        if (hs_cyc.size() == 3) begin
            chk("b2b_gap0", W'(hs_cyc[1] - hs_cyc[0]), W'(L + 1));
            chk("b2b_gap1", W'(hs_cyc[2] - hs_cyc[1]), W'(L + 1));
        end

        // Backpressure on the top address
        RspReady_SI = 1'b0;
        req(8'hFF, 1'b0, t);
        wait_valid();
        repeat (5) tick();
        chk("bp_valid_held", W'(RspValid_SO), W'(1));
        chk("bp_req_ready", W'(ReqReady_SO), W'(0));
        RspReady_SI = 1'b1;
        tick();
        nhs++;
        chk("bp_release_count", W'(hs_count), W'(nhs));
        chk("bp_release_valid", W'(RspValid_SO), W'(0));
        chk("bp_idle_ready", W'(ReqReady_SO), W'(1));
        chk("bp_im_kept", IMOut_DO, 64'hFFFF_0000_FFFF_0000);

        // Load and request in the same IDLE cycle
        ReqValid_SI = 1'b1;
        Addr_DI     = 8'h05;
        LoadEn_SI   = 1'b1;
        LoadSel_DI  = 2'd0;
        LoadAddr_DI = 8'h05;
        LoadData_DI = 64'hCAFE_F00D_1234_5678;
        m_im[5]     = 64'hCAFE_F00D_1234_5678;
        #1;
        chk("conflict_req_ready", W'(ReqReady_SO), W'(0));
        tick();
        LoadEn_SI = 1'b0;
        req(8'h05, 1'b0, t);
        chk("conflict_next_cycle", W'(t), W'(1));
        nhs++;
        wait_hs(nhs);

        // Load during READ is dropped
        req(8'h01, 1'b0, t);
        LoadEn_SI   = 1'b1;
        LoadSel_DI  = 2'd1;
        LoadAddr_DI = 8'h01;
        LoadData_DI = 64'h0000_0000_0000_0BAD;
        tick();
        LoadEn_SI = 1'b0;
        chk("dropped_set", W'(LoadDropped_SO), W'(1));
        nhs++;
        wait_hs(nhs);
        req(8'h01, 1'b0, t);
        nhs++;
        wait_hs(nhs);
        chk("dropped_sticky", W'(LoadDropped_SO), W'(1));

        // Reset mid-HOLD
        RspReady_SI = 1'b0;
        req(8'h02, 1'b0, t);
        wait_valid();
        Reset_RI = 1'b0;
        exp_q.delete();
        tick();
        chk("rst_hold_valid", W'(RspValid_SO), W'(0));
        chk("rst_hold_im", IMOut_DO, P_ZERO);
        chk("rst_hold_neg", ProjNegOut_DO, P_ZERO);
        chk("rst_hold_pos", ProjPosOut_DO, P_ZERO);
        chk("rst_hold_dropped", W'(LoadDropped_SO), W'(0));
        Reset_RI    = 1'b1;
        RspReady_SI = 1'b1;
        tick();
        req(8'h02, 1'b0, t);
        nhs++;
        wait_hs(nhs);
        chk("final_queue_empty", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
